// File: rtl/spi_pkg.sv
// spi_pkg: frame codes, sequencer state type and frame word builder
// shared by the SPI master frame engine and the command sequencer.
package spi_pkg;

  localparam logic [1:0] CODE_WR_ADDR = 2'b00;
  localparam logic [1:0] CODE_WR_DATA = 2'b01;
  localparam logic [1:0] CODE_RD_ADDR = 2'b10;
  localparam logic [1:0] CODE_RD_DATA = 2'b11;

  localparam int PAYLOAD_MAX = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_SHIFT,
    ST_WAIT,
    ST_RECV,
    ST_GAP
  } state_t;

  // Returns {code, payload} with the code placed just above an
  // aw-bit payload; callers cast the result down to aw+2 bits.
  function automatic logic [PAYLOAD_MAX+1:0] build_frame(
    input logic [1:0]             code,
    input logic [PAYLOAD_MAX-1:0] payload,
    input int                     aw
  );
    logic [PAYLOAD_MAX+1:0] f;
    f = {2'b00, payload};
    f = f | ({{PAYLOAD_MAX{1'b0}}, code} << aw);
    return f;
  endfunction

endpackage

// File: rtl/spi_master_seq_frame_engine.sv
// spi_frame_engine: runs one SPI frame START..GAP with optional WAIT/RECV.
// Ports: start/frame/rx_en in, done/rx_word out, SS_n/MOSI/MISO pins.
module spi_frame_engine
  import spi_pkg::*;
#(
  parameter int  ADDR_SIZE = 8,
  parameter int  RD_WAIT   = 2,
  localparam int FW        = ADDR_SIZE + 2,
  localparam int CW        = $clog2(ADDR_SIZE + 2) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [FW-1:0]        frame,
  input  logic                 rx_en,
  input  logic                 MISO,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] rx_word,
  output logic                 SS_n,
  output logic                 MOSI
);

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [FW-1:0]        sh, sh_d;
  logic [ADDR_SIZE-1:0] rx_sh, rx_d;
  logic                 rx_en_q, rx_en_d;
  logic                 ss_n_d, mosi_d;

  assign rx_word = rx_d;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sh_d    = sh;
    rx_d    = rx_sh;
    rx_en_d = rx_en_q;
    done    = 1'b0;
    unique case (state)
      ST_IDLE, ST_GAP: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_START;
          sh_d    = frame;
          rx_en_d = rx_en;
        end
      end
      ST_START: state_d = ST_CMD;
      ST_CMD: begin
        state_d = ST_SHIFT;
        cnt_d   = CW'(FW - 1);
      end
      ST_SHIFT: begin
        if (cnt == '0) begin
          if (!rx_en_q) begin
            state_d = ST_GAP;
            done    = 1'b1;
          end else if (RD_WAIT > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CW'(RD_WAIT - 1);
          end else begin
            state_d = ST_RECV;
            cnt_d   = CW'(ADDR_SIZE - 1);
          end
        end else begin
          cnt_d = cnt - CW'(1);
          sh_d  = sh << 1;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_d = ST_RECV;
          cnt_d   = CW'(ADDR_SIZE - 1);
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      ST_RECV: begin
        rx_d = {rx_sh[ADDR_SIZE-2:0], MISO};
        if (cnt == '0) begin
          state_d = ST_GAP;
          done    = 1'b1;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Pins are registered from the next state so they line up
    // exactly with the state the engine is about to occupy.
    ss_n_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
    mosi_d = 1'b0;
    if ((state_d == ST_CMD) || (state_d == ST_SHIFT)) begin
      mosi_d = sh_d[FW-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sh      <= '0;
      rx_sh   <= '0;
      rx_en_q <= 1'b0;
      SS_n    <= 1'b1;
      MOSI    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      sh      <= sh_d;
      rx_sh   <= rx_d;
      rx_en_q <= rx_en_d;
      SS_n    <= ss_n_d;
      MOSI    <= mosi_d;
    end
  end

endmodule

// File: rtl/spi_master_seq.sv
// spi_master_seq: expands host write/read commands into two SPI frames.
// Ports: cmd_* host request, rsp_* read return, busy, SS_n/MOSI/MISO pins.
module spi_master_seq
  import spi_pkg::*;
#(
  parameter int  MEM_DEPTH = 256,
  parameter int  RD_WAIT   = 2,
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH),
  localparam int FW        = ADDR_SIZE + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_rd,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [ADDR_SIZE-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_data,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  logic                 accept;
  logic                 step;
  logic                 pend;
  logic                 fin;
  logic                 rd_q;
  logic [ADDR_SIZE-1:0] wdata_q;
  logic [1:0]           code_sel;
  logic [ADDR_SIZE-1:0] pay_sel;
  logic [FW-1:0]        eng_frame;
  logic                 eng_start;
  logic                 eng_rx_en;
  logic                 eng_done;
  logic [ADDR_SIZE-1:0] eng_rx;

  assign accept = cmd_valid && cmd_ready;

  // First frame comes straight from the host inputs on acceptance;
  // the second is issued from the captured copy during the GAP.
  always_comb begin
    code_sel = cmd_rd ? CODE_RD_ADDR : CODE_WR_ADDR;
    pay_sel  = cmd_addr;
    if (!accept) begin
      code_sel = rd_q ? CODE_RD_DATA : CODE_WR_DATA;
      pay_sel  = rd_q ? '0 : wdata_q;
    end
  end

  assign eng_frame = FW'(build_frame(code_sel,
                                     PAYLOAD_MAX'(pay_sel),
                                     ADDR_SIZE));
  assign eng_start = accept || pend;
  assign eng_rx_en = pend && rd_q;

  spi_frame_engine #(
    .ADDR_SIZE (ADDR_SIZE),
    .RD_WAIT   (RD_WAIT)
  ) u_engine (
    .clk     (clk),
    .rst     (rst),
    .start   (eng_start),
    .frame   (eng_frame),
    .rx_en   (eng_rx_en),
    .MISO    (MISO),
    .done    (eng_done),
    .rx_word (eng_rx),
    .SS_n    (SS_n),
    .MOSI    (MOSI)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      step      <= 1'b0;
      pend      <= 1'b0;
      fin       <= 1'b0;
      rd_q      <= 1'b0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      pend      <= 1'b0;
      if (accept) begin
        cmd_ready <= 1'b0;
        busy      <= 1'b1;
        step      <= 1'b0;
        rd_q      <= cmd_rd;
        wdata_q   <= cmd_wdata;
      end
      if (eng_done && !step) begin
        pend <= 1'b1;
        step <= 1'b1;
      end
      if (eng_done && step) begin
        fin <= 1'b1;
        if (rd_q) begin
          rsp_valid <= 1'b1;
          rsp_data  <= eng_rx;
        end
      end
      if (fin) begin
        fin       <= 1'b0;
        cmd_ready <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_seq.sv
// tb_spi_master_seq: scoreboard bench with a frame-level slave+RAM model.
// Second instance uses RD_WAIT=4 with a fixed MISO pattern.
module tb_spi_master_seq;

  localparam int RDW  = 2;
  localparam int RDW4 = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rd = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       ss_n;
  logic       mosi;
  logic       miso = 1'b0;

  logic       rst4 = 1'b1;
  logic       cmd_valid4 = 1'b0;
  logic       cmd_ready4;
  logic       cmd_rd4 = 1'b0;
  logic [7:0] cmd_addr4 = '0;
  logic [7:0] cmd_wdata4 = '0;
  logic       rsp_valid4;
  logic [7:0] rsp_data4;
  logic       busy4;
  logic       ss_n4;
  logic       mosi4;
  logic       miso4 = 1'b0;

  spi_master_seq #(.MEM_DEPTH(256), .RD_WAIT(RDW)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
  );

  spi_master_seq #(.MEM_DEPTH(256), .RD_WAIT(RDW4)) u_dut4 (
    .clk(clk), .rst(rst4), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_rd(cmd_rd4), .cmd_addr(cmd_addr4), .cmd_wdata(cmd_wdata4),
    .rsp_valid(rsp_valid4), .rsp_data(rsp_data4), .busy(busy4),
    .SS_n(ss_n4), .MOSI(mosi4), .MISO(miso4)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Host-level reference memory and the slave-side RAM built from frames.
  logic [7:0] ref_mem [256];
  logic [7:0] smem [256];
  logic [9:0] exp_frames [$];
  logic [7:0] exp_rsp [$];
  logic       aborting = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      smem[i] = '0;
    end
  end

  // Slave model: collects MOSI per SS_n-low cycle, drives MISO in the
  // receive window of a read-data frame, random noise elsewhere.
  int         k = 0;
  logic       fb [$];
  logic [7:0] s_addr = '0;
  logic [7:0] s_raddr = '0;

  task automatic end_frame(input int n);
    logic [9:0] f;
    logic [9:0] e;
    f = '0;
    for (int i = 2; i < 12 && i < n; i++) f = {f[8:0], fb[i]};
    if (aborting) begin
      if (exp_frames.size() > 0) void'(exp_frames.pop_front());
    end else begin
      chk("frame_pending", exp_frames.size() > 0, 1);
      e = 10'h3ff;
      if (exp_frames.size() > 0) e = exp_frames.pop_front();
      chk("frame_word", f, e);
      chk("frame_len", n, (e[9:8] == 2'b11) ? 20 + RDW : 12);
      chk("start_bit", fb[0], 1'b0);
      chk("cmd_bit", fb[1], e[9]);
      if (e[9:8] == 2'b11)
        for (int i = 12; i < 12 + RDW && i < n; i++)
          chk("wait_mosi", fb[i], 1'b0);
      if (n >= 12) begin
        case (f[9:8])
          2'b00: s_addr = f[7:0];
          2'b01: smem[s_addr] = f[7:0];
          2'b10: s_raddr = f[7:0];
          default: ;
        endcase
      end
    end
  endtask

  always @(negedge clk) begin
    if (!ss_n) begin
      fb.push_back(mosi);
      if (k >= 12 + RDW && k < 20 + RDW && fb.size() > 3 && fb[2] && fb[3])
        miso = smem[s_raddr][3'(19 + RDW - k)];
      else
        miso = 1'($urandom);
      k++;
    end else begin
      miso = 1'($urandom);
      if (k > 0) end_frame(k);
      k = 0;
      fb.delete();
    end
  end

  // Response monitor.
  logic       rst_seen = 1'b1;
  logic [7:0] last_rsp = '0;
  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    if (rst_seen) begin
      chk("rst_rsp_data", rsp_data, 8'h00);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      last_rsp = '0;
    end else if (rsp_valid) begin
      chk("rsp_expected", exp_rsp.size() > 0, 1);
      if (exp_rsp.size() > 0) chk("rsp_data", rsp_data, exp_rsp.pop_front());
      chk("rsp_in_gap", ss_n, 1'b1);
      last_rsp = rsp_data;
    end else begin
      chk("rsp_hold", rsp_data, last_rsp);
    end
  end

  task automatic issue(input logic rd, input logic [7:0] a,
                       input logic [7:0] d, input logic hold);
    int n;
    int rn;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", cmd_ready, 1'b1);
    if (!cmd_ready) return;
    cmd_valid = 1'b1;
    cmd_rd = rd;
    cmd_addr = a;
    cmd_wdata = d;
    if (rd) begin
      exp_frames.push_back({2'b10, a});
      exp_frames.push_back({2'b11, 8'h00});
      exp_rsp.push_back(ref_mem[a]);
    end else begin
      exp_frames.push_back({2'b00, a});
      exp_frames.push_back({2'b01, d});
      ref_mem[a] = d;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    n = 0;
    rn = -1;
    while (!cmd_ready && n < 100) begin
      if (hold) begin
        cmd_rd = 1'($urandom);
        cmd_addr = 8'($urandom);
        cmd_wdata = 8'($urandom);
      end
      if (rsp_valid) rn = n;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk(rd ? "rd_latency" : "wr_latency", n, rd ? 36 : 26);
    if (rd) chk("rsp_before_ready", rn, n - 1);
  endtask

  // RD_WAIT=4 instance: the pattern must land in the shifted window.
  logic       done4 = 1'b0;
  int         k4 = 0;
  logic [7:0] pat4 = 8'h81;

  always @(negedge clk) begin
    if (!ss_n4) begin
      if (k4 >= 12 + RDW4 && k4 < 20 + RDW4) miso4 = pat4[3'(19 + RDW4 - k4)];
      else miso4 = 1'($urandom);
      k4++;
    end else begin
      k4 = 0;
      miso4 = 1'($urandom);
    end
  end

  initial begin
    int n;
    int rn;
    logic [7:0] got;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst4 = 1'b0;
    @(negedge clk);
    cmd_valid4 = 1'b1;
    cmd_rd4 = 1'b1;
    cmd_addr4 = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    cmd_valid4 = 1'b0;
    n = 0;
    rn = -1;
    got = '0;
    while (!cmd_ready4 && n < 100) begin
      if (rsp_valid4) begin
        rn = n;
        got = rsp_data4;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("rdw4_latency", n, 36 + RDW4 - RDW);
    chk("rdw4_rsp_cycle", rn, n - 1);
    chk("rdw4_rsp_data", got, 8'h81);
    done4 = 1'b1;
  end

  initial begin
    int n;
    logic [7:0] a;
    // Reset with a command strobe present that must be ignored.
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_addr = 8'h11;
    cmd_wdata = 8'h22;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ss_n", ss_n, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_ss", ss_n, 1'b1);
    chk("post_rst_idle_busy", busy, 1'b0);

    issue(1'b0, 8'h3C, 8'hA5, 1'b0);
    issue(1'b1, 8'h3C, 8'h00, 1'b0);

    issue(1'b0, 8'h00, 8'hFF, 1'b1);
    issue(1'b0, 8'hFF, 8'h00, 1'b1);
    issue(1'b1, 8'h00, 8'h00, 1'b1);
    issue(1'b1, 8'hFF, 8'h00, 1'b1);

    // Read aborted by reset at frame-2 cycle k=5.
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rd = 1'b1;
    cmd_addr = 8'h3C;
    exp_frames.push_back({2'b10, 8'h3C});
    exp_frames.push_back({2'b11, 8'h00});
    aborting = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (18) @(negedge clk);
    chk("abort_point_busy", busy, 1'b1);
    chk("abort_point_ss", ss_n, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ss_n", ss_n, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    aborting = 1'b0;
    repeat (40) @(negedge clk);
    issue(1'b1, 8'h3C, 8'h00, 1'b0);

    a = 8'($urandom);
    issue(1'b0, a, 8'h81, 1'b0);
    issue(1'b1, a, 8'h00, 1'b0);

    for (int i = 0; i < 30; i++)
      issue(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));

    repeat (5) @(negedge clk);
    chk("frames_drained", exp_frames.size(), 0);
    chk("rsp_drained", exp_rsp.size(), 0);
    n = 0;
    while (!done4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rdw4_done", done4, 1'b1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
